// File: rtl/sprite_box_tracker.sv
// sprite_box_tracker: frame-synchronous hitbox/hurtbox generator for one fighter.
// Fighter state and position are latched on each frame_tick, and the box outputs
// stay stable until the next tick. The block also handles runtime facing, a
// hitbox that grows over the active frames, one-hit-per-attack consumption and
// clipping of the boxes to the screen edges.
module sprite_box_tracker #(
   parameter int COORD_W       = 10,
   parameter int SPRITE_WIDTH  = 64,
   parameter int SPRITE_HEIGHT = 128,
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int HURT_MARGIN   = 10,
   parameter int REC_MARGIN    = 5,
   parameter int HIT_START_W   = 10,
   parameter int GROW_STEP     = 8,
   parameter int BASIC_W       = 30,
   parameter int BASIC_H       = 60,
   parameter int DIR_W         = 40,
   parameter int DIR_H         = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic [3:0]         state,
   input  logic [COORD_W-1:0] sprite_x,
   input  logic [COORD_W-1:0] sprite_y,
   input  logic               facing_left,
   input  logic               hit_ack,
   output logic [COORD_W-1:0] hitbox_x1,
   output logic [COORD_W-1:0] hitbox_x2,
   output logic [COORD_W-1:0] hitbox_y1,
   output logic [COORD_W-1:0] hitbox_y2,
   output logic [COORD_W-1:0] hurtbox_x1,
   output logic [COORD_W-1:0] hurtbox_x2,
   output logic [COORD_W-1:0] hurtbox_y1,
   output logic [COORD_W-1:0] hurtbox_y2,
   output logic               hitbox_active,
   output logic               hurtbox_active,
   output logic               boxes_valid
);

   // Two extra bits so that sums past the screen edge and negative left-facing
   // positions can both be represented before clipping.
   localparam int SW = COORD_W + 2;
   typedef logic signed [SW-1:0] s_t;

   localparam s_t L_ZERO       = s_t'(0);
   localparam s_t L_SPRITE_W   = s_t'(SPRITE_WIDTH);
   localparam s_t L_SPRITE_H   = s_t'(SPRITE_HEIGHT);
   localparam s_t L_XSCR       = s_t'(SCREEN_W);
   localparam s_t L_XMAX       = s_t'(SCREEN_W - 1);
   localparam s_t L_YMAX       = s_t'(SCREEN_H - 1);
   localparam s_t L_HURT_M     = s_t'(HURT_MARGIN);
   localparam s_t L_REC_M      = s_t'(REC_MARGIN);
   localparam s_t L_START      = s_t'(HIT_START_W);
   localparam s_t L_STEP       = s_t'(GROW_STEP);
   localparam s_t L_BASIC_W    = s_t'(BASIC_W);
   localparam s_t L_BASIC_H    = s_t'(BASIC_H);
   localparam s_t L_DIR_W      = s_t'(DIR_W);
   localparam s_t L_DIR_H      = s_t'(DIR_H);
   localparam s_t L_BASIC_YOFF = s_t'((SPRITE_HEIGHT - BASIC_H) / 2);
   localparam s_t L_DIR_YOFF   = s_t'((SPRITE_HEIGHT - DIR_H) / 2);

   // Latched context from the previous tick
   logic [3:0]         r_state;
   logic [3:0]         r_k;
   logic               r_spent;
   // Box registers, index order: hit x1,x2,y1,y2 then hurt x1,x2,y1,y2
   logic [COORD_W-1:0] r_box [0:7];
   logic               r_hitbox_active;
   logic               r_hurtbox_active;
   logic               r_boxes_valid;

   logic               w_new_active;
   logic               w_is_dir;
   logic               w_is_rec;
   logic               w_continue;
   logic [3:0]         w_k_next;
   logic               w_spent_next;
   s_t                 w_sx;
   s_t                 w_sy;
   s_t                 w_grow;
   s_t                 w_wmax;
   s_t                 w_w;
   s_t                 w_h;
   s_t                 w_yoff;
   s_t                 w_m;
   s_t                 w_raw  [0:7];
   logic [COORD_W-1:0] w_clip [0:7];
   logic               w_offscreen;
   logic               w_hit_ok;

   assign w_new_active = (state == 4'd4) || (state == 4'd7);
   assign w_is_dir     = (state == 4'd7);
   assign w_is_rec     = (state == 4'd5) || (state == 4'd8);

   // The same active attack seen on consecutive ticks advances the frame counter.
   // A landed hit (earlier, or acked on this very tick) stays consumed only
   // while that attack continues.
   assign w_continue   = w_new_active && (state == r_state);
   assign w_k_next     = !w_continue ? 4'd0 : ((r_k == 4'd15) ? 4'd15 : r_k + 4'd1);
   assign w_spent_next = w_continue && (r_spent || hit_ack);

   assign w_sx   = $signed({2'b00, sprite_x});
   assign w_sy   = $signed({2'b00, sprite_y});
   assign w_grow = L_START + $signed({{(SW-4){1'b0}}, w_k_next}) * L_STEP;
   assign w_wmax = w_is_dir ? L_DIR_W : L_BASIC_W;
   assign w_w    = (w_grow > w_wmax) ? w_wmax : w_grow;
   assign w_h    = w_is_dir ? L_DIR_H : L_BASIC_H;
   assign w_yoff = w_is_dir ? L_DIR_YOFF : L_BASIC_YOFF;
   assign w_m    = w_is_rec ? L_REC_M : L_HURT_M;

   // Unclipped box corners for the state being sampled
   always_comb begin
      w_raw[0] = w_sx + L_SPRITE_W;
      w_raw[1] = w_sx + L_SPRITE_W + w_w;
      if (facing_left) begin
         w_raw[0] = w_sx - w_w;
         w_raw[1] = w_sx;
      end
      w_raw[2] = w_sy + w_yoff;
      w_raw[3] = w_sy + w_yoff + w_h;
      w_raw[4] = w_sx + w_m;
      w_raw[5] = w_sx + L_SPRITE_W - w_m;
      w_raw[6] = w_sy;
      w_raw[7] = w_sy + L_SPRITE_H;
   end

   // Clip every corner to the visible area: x uses the screen width, y the height
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_clip
         localparam s_t LIM = ((gi % 4) < 2) ? L_XMAX : L_YMAX;
         assign w_clip[gi] = (w_raw[gi] < L_ZERO) ? '0 :
                             (w_raw[gi] > LIM)    ? LIM[COORD_W-1:0] :
                                                    w_raw[gi][COORD_W-1:0];
      end
   endgenerate

   // A hitbox that starts wholly beyond the facing-side edge is never live,
   // even though clipping would give it a non-degenerate shape.
   assign w_offscreen = facing_left ? (w_raw[1] == L_ZERO) : (w_raw[0] >= L_XSCR);
   assign w_hit_ok    = w_new_active && !w_spent_next && !w_offscreen &&
                        (w_clip[0] < w_clip[1]) && (w_clip[2] < w_clip[3]);

   // Latch context and boxes on each tick; a hit ack between ticks only drops the hitbox
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state          <= '0;
         r_k              <= '0;
         r_spent          <= 1'b0;
         r_hitbox_active  <= 1'b0;
         r_hurtbox_active <= 1'b0;
         r_boxes_valid    <= 1'b0;
         for (int i = 0; i < 8; i++) r_box[i] <= '0;
      end else begin
         r_boxes_valid <= frame_tick;
         if (frame_tick) begin
            r_state          <= state;
            r_k              <= w_k_next;
            r_spent          <= w_spent_next;
            r_hitbox_active  <= w_hit_ok;
            r_hurtbox_active <= 1'b1;
            for (int i = 0; i < 4; i++) r_box[i] <= w_new_active ? w_clip[i] : '0;
            for (int i = 4; i < 8; i++) r_box[i] <= w_clip[i];
         end else if (hit_ack) begin
            r_spent         <= 1'b1;
            r_hitbox_active <= 1'b0;
         end
      end
   end

   assign hitbox_x1      = r_box[0];
   assign hitbox_x2      = r_box[1];
   assign hitbox_y1      = r_box[2];
   assign hitbox_y2      = r_box[3];
   assign hurtbox_x1     = r_box[4];
   assign hurtbox_x2     = r_box[5];
   assign hurtbox_y1     = r_box[6];
   assign hurtbox_y2     = r_box[7];
   assign hitbox_active  = r_hitbox_active;
   assign hurtbox_active = r_hurtbox_active;
   assign boxes_valid    = r_boxes_valid;

endmodule

// File: tb/tb_sprite_box_tracker.sv
// Bench for sprite_box_tracker: directed ticks push hand-computed boxes into a
// scoreboard queue; a monitor pops and compares on every boxes_valid pulse.
module tb_sprite_box_tracker;

   typedef struct packed {
      logic [9:0] hx1, hx2, hy1, hy2;
      logic [9:0] ux1, ux2, uy1, uy2;
      logic       ha, ua;
   } box_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick = 1'b0;
   logic [3:0] state = 4'd0;
   logic [9:0] sprite_x = '0;
   logic [9:0] sprite_y = '0;
   logic       facing_left = 1'b0;
   logic       hit_ack = 1'b0;
   logic [9:0] hitbox_x1, hitbox_x2, hitbox_y1, hitbox_y2;
   logic [9:0] hurtbox_x1, hurtbox_x2, hurtbox_y1, hurtbox_y2;
   logic       hitbox_active, hurtbox_active, boxes_valid;

   int   errors = 0;
   int   checks = 0;
   int   txn = 0;
   box_t sb[$];

   sprite_box_tracker dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .state(state),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .facing_left(facing_left),
      .hit_ack(hit_ack),
      .hitbox_x1(hitbox_x1), .hitbox_x2(hitbox_x2),
      .hitbox_y1(hitbox_y1), .hitbox_y2(hitbox_y2),
      .hurtbox_x1(hurtbox_x1), .hurtbox_x2(hurtbox_x2),
      .hurtbox_y1(hurtbox_y1), .hurtbox_y2(hurtbox_y2),
      .hitbox_active(hitbox_active), .hurtbox_active(hurtbox_active),
      .boxes_valid(boxes_valid)
   );

   always #5 clk = ~clk;

   function automatic box_t mk(input int a, b, c, d, e, f, g, h, input bit ha, ua);
      box_t r;
      r.hx1 = 10'(a); r.hx2 = 10'(b); r.hy1 = 10'(c); r.hy2 = 10'(d);
      r.ux1 = 10'(e); r.ux2 = 10'(f); r.uy1 = 10'(g); r.uy2 = 10'(h);
      r.ha = ha; r.ua = ua;
      return r;
   endfunction

   function automatic box_t cur();
      box_t r;
      r.hx1 = hitbox_x1;  r.hx2 = hitbox_x2;  r.hy1 = hitbox_y1;  r.hy2 = hitbox_y2;
      r.ux1 = hurtbox_x1; r.ux2 = hurtbox_x2; r.uy1 = hurtbox_y1; r.uy2 = hurtbox_y2;
      r.ha = hitbox_active; r.ua = hurtbox_active;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end else
         $display("ok   %s: %0h", name, got);
   endtask

   // Monitor: every valid pulse must match the oldest expected box
   always @(negedge clk) begin
      if (boxes_valid) begin
         box_t g, e;
         g = cur();
         checks++;
         txn++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL txn%0d: unexpected boxes_valid, got hit=(%0d,%0d,%0d,%0d) a=%0b",
                     txn, g.hx1, g.hx2, g.hy1, g.hy2, g.ha);
         end else begin
            e = sb.pop_front();
            if (g !== e) begin
               errors++;
               $display("FAIL txn%0d: got hit=(%0d,%0d,%0d,%0d) a=%0b hurt=(%0d,%0d,%0d,%0d) a=%0b want hit=(%0d,%0d,%0d,%0d) a=%0b hurt=(%0d,%0d,%0d,%0d) a=%0b",
                        txn, g.hx1, g.hx2, g.hy1, g.hy2, g.ha, g.ux1, g.ux2, g.uy1, g.uy2, g.ua,
                        e.hx1, e.hx2, e.hy1, e.hy2, e.ha, e.ux1, e.ux2, e.uy1, e.uy2, e.ua);
            end else
               $display("txn%0d: hit=(%0d,%0d,%0d,%0d) a=%0b hurt=(%0d,%0d,%0d,%0d) a=%0b",
                        txn, g.hx1, g.hx2, g.hy1, g.hy2, g.ha, g.ux1, g.ux2, g.uy1, g.uy2, g.ua);
         end
      end
   end

   task automatic tick(input logic [3:0] st, input int x, input int y, input bit fl,
                       input bit ack, input box_t e);
      state = st; sprite_x = 10'(x); sprite_y = 10'(y); facing_left = fl;
      hit_ack = ack; frame_tick = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      frame_tick = 1'b0; hit_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_state", {cur(), boxes_valid}, '0);

      // Basic attack growing over four frames
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));
      tick(4, 100, 200, 0, 0, mk(164, 182, 234, 294, 110, 154, 200, 328, 1, 1));
      tick(4, 100, 200, 0, 0, mk(164, 190, 234, 294, 110, 154, 200, 328, 1, 1));
      tick(4, 100, 200, 0, 0, mk(164, 194, 234, 294, 110, 154, 200, 328, 1, 1));

      // Inputs moving between ticks must not disturb the held boxes
      state = 4'd7; sprite_x = 10'd300; sprite_y = 10'd10;
      repeat (3) @(posedge clk);
      #1;
      chk("hold_hit_x2", hitbox_x2, 194);
      chk("hold_hurt_x1", hurtbox_x1, 110);

      // Directional attack facing left, clipped at the left edge
      tick(7, 20, 200, 1, 0, mk(10, 20, 240, 288, 30, 74, 200, 328, 1, 1));
      tick(7, 20, 200, 1, 0, mk(2, 20, 240, 288, 30, 74, 200, 328, 1, 1));
      tick(7, 20, 200, 1, 0, mk(0, 20, 240, 288, 30, 74, 200, 328, 1, 1));

      // Right edge: fully offscreen, then partially clipped
      tick(4, 580, 200, 0, 0, mk(639, 639, 234, 294, 590, 634, 200, 328, 0, 1));
      tick(4, 560, 200, 0, 0, mk(624, 639, 234, 294, 570, 614, 200, 328, 1, 1));
      tick(4, 560, 200, 0, 0, mk(624, 639, 234, 294, 570, 614, 200, 328, 1, 1));
      tick(4, 560, 200, 0, 0, mk(624, 639, 234, 294, 570, 614, 200, 328, 1, 1));

      // Recovery near the bottom edge
      tick(5, 100, 400, 0, 0, mk(0, 0, 0, 0, 105, 159, 400, 479, 0, 1));

      // Hit consumption
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));
      tick(4, 100, 200, 0, 0, mk(164, 182, 234, 294, 110, 154, 200, 328, 1, 1));
      hit_ack = 1'b1;
      @(posedge clk); #1;
      hit_ack = 1'b0;
      chk("ack_drop_active", hitbox_active, 0);
      chk("ack_hold_x2", hitbox_x2, 182);
      tick(4, 100, 200, 0, 0, mk(164, 190, 234, 294, 110, 154, 200, 328, 0, 1));
      tick(5, 100, 200, 0, 0, mk(0, 0, 0, 0, 105, 159, 200, 328, 0, 1));
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));
      // Ack with a tick that changes attack is discarded; with the same attack it sticks
      tick(7, 100, 200, 0, 1, mk(164, 174, 240, 288, 110, 154, 200, 328, 1, 1));
      tick(7, 100, 200, 0, 1, mk(164, 182, 240, 288, 110, 154, 200, 328, 0, 1));

      // Left-facing box at x=0 is offscreen
      tick(8, 0, 0, 1, 0, mk(0, 0, 0, 0, 5, 59, 0, 128, 0, 1));
      tick(7, 0, 0, 1, 0, mk(0, 0, 40, 88, 10, 54, 0, 128, 0, 1));

      // Reset between ticks
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));
      tick(4, 100, 200, 0, 0, mk(164, 182, 234, 294, 110, 154, 200, 328, 1, 1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_idle", {cur(), boxes_valid}, '0);

      // Reset coincident with a tick: no update, no valid pulse
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));
      state = 4'd4; sprite_x = 10'd100; sprite_y = 10'd200; facing_left = 1'b0;
      rst = 1'b1; frame_tick = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; frame_tick = 1'b0;
      chk("rst_with_tick", {cur(), boxes_valid}, '0);
      repeat (2) @(posedge clk);
      #1;
      tick(4, 100, 200, 0, 0, mk(164, 174, 234, 294, 110, 154, 200, 328, 1, 1));

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 128'(sb.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
